// File: rtl/mc_mainfsm_if.sv
// rtl/mc_mainfsm_if.sv - instruction-field inputs and datapath control outputs of mc_mainfsm (MEM_WAIT_EN adds MemReady)
interface mc_mainfsm_if #(
    parameter int ICNT_W = 16
);
    logic [1:0]        Op;
    logic [5:0]        Funct;
`ifdef MEM_WAIT_EN
    logic              MemReady;
`endif
    logic              IRWrite;
    logic              NextPC;
    logic              AdrSrc;
    logic [1:0]        ALUSrcA;
    logic [1:0]        ALUSrcB;
    logic [1:0]        ResultSrc;
    logic              ALUOp;
    logic              RegW;
    logic              MemW;
    logic              Branch;
    logic              Undef;
    logic [ICNT_W-1:0] InstrCount;

`ifdef MEM_WAIT_EN
    modport master (
        output Op, Funct, MemReady,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, RegW, MemW, Branch, Undef, InstrCount
    );
    modport slave (
        input  Op, Funct, MemReady,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, RegW, MemW, Branch, Undef, InstrCount
    );
`else
    modport master (
        output Op, Funct,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, RegW, MemW, Branch, Undef, InstrCount
    );
    modport slave (
        input  Op, Funct,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, RegW, MemW, Branch, Undef, InstrCount
    );
`endif
endinterface

// File: rtl/mc_mainfsm.sv
// rtl/mc_mainfsm.sv - multicycle ARM main control FSM with retired-instruction counter (optional MEM_WAIT_EN memory stalls)
module mc_mainfsm #(
    parameter int ICNT_W = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    mc_mainfsm_if.slave  bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_UNKNOWN = 4'd10
    } state_t;

    state_t            state_q, state_d;
    logic [ICNT_W-1:0] icnt_q, icnt_d;
    logic              mem_ready;
    logic              unused_funct;

`ifdef MEM_WAIT_EN
    assign mem_ready = bus.MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    // Only Funct[5] (I) and Funct[0] (S/L) steer the sequence.
    assign unused_funct = ^bus.Funct[4:1];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_FETCH;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                    icnt_d  = icnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                case (bus.Op)
                    2'b00:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR: state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_UNKNOWN: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Reset gates the decode so outputs drop at once, even mid-instruction.
    always_comb begin
        bus.IRWrite   = 1'b0;
        bus.NextPC    = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.ResultSrc = 2'b00;
        bus.ALUOp     = 1'b0;
        bus.RegW      = 1'b0;
        bus.MemW      = 1'b0;
        bus.Branch    = 1'b0;
        bus.Undef     = 1'b0;
        if (Rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.IRWrite   = 1'b1;
                    bus.NextPC    = 1'b1;
                    bus.ALUSrcA   = 2'b01;
                    bus.ALUSrcB   = 2'b10;
                    bus.ResultSrc = 2'b10;
                end
                S_DECODE: begin
                    bus.ALUSrcA   = 2'b01;
                    bus.ALUSrcB   = 2'b10;
                    bus.ResultSrc = 2'b10;
                end
                S_MEMADR: bus.ALUSrcB = 2'b01;
                S_MEMRD:  bus.AdrSrc  = 1'b1;
                S_MEMWB: begin
                    bus.ResultSrc = 2'b01;
                    bus.RegW      = 1'b1;
                end
                S_MEMWR: begin
                    bus.AdrSrc = 1'b1;
                    bus.MemW   = 1'b1;
                end
                S_EXECR: bus.ALUOp = 1'b1;
                S_EXECI: begin
                    bus.ALUSrcB = 2'b01;
                    bus.ALUOp   = 1'b1;
                end
                S_ALUWB: bus.RegW = 1'b1;
                S_BRANCH: begin
                    bus.ALUSrcB   = 2'b01;
                    bus.ResultSrc = 2'b10;
                    bus.Branch    = 1'b1;
                end
                S_UNKNOWN: bus.Undef = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.InstrCount = icnt_q;

endmodule

// File: tb/tb_mc_mainfsm.sv
// tb/tb_mc_mainfsm.sv - self-checking bench for mc_mainfsm against an instruction-level phase model
module tb_mc_mainfsm;

    localparam int W = 4;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    mc_mainfsm_if #(.ICNT_W(W)) bus_if();
    mc_mainfsm #(.ICNT_W(W)) dut (.Clk(Clk), .Rst(Rst), .bus(bus_if));

    typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                  P_EXECR, P_EXECI, P_ALUWB, P_BRANCH, P_UNDEF} phase_t;

    int n_cmp = 0;
    int n_err = 0;
    int model_cnt = 0;

    logic [14:0] obs;
    assign obs = {bus_if.IRWrite, bus_if.NextPC, bus_if.AdrSrc, bus_if.ALUSrcA,
                  bus_if.ALUSrcB, bus_if.ResultSrc, bus_if.ALUOp, bus_if.RegW,
                  bus_if.MemW, bus_if.Branch, bus_if.Undef};

    // {IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,RegW,MemW,Branch,Undef}
    function automatic logic [14:0] exp_vec(input phase_t p);
        case (p)
            P_FETCH:  return 15'b1_1_0_01_10_10_0_0_0_0_0;
            P_DECODE: return 15'b0_0_0_01_10_10_0_0_0_0_0;
            P_MEMADR: return 15'b0_0_0_00_01_00_0_0_0_0_0;
            P_MEMRD:  return 15'b0_0_1_00_00_00_0_0_0_0_0;
            P_MEMWB:  return 15'b0_0_0_00_00_01_0_1_0_0_0;
            P_MEMWR:  return 15'b0_0_1_00_00_00_0_0_1_0_0;
            P_EXECR:  return 15'b0_0_0_00_00_00_1_0_0_0_0;
            P_EXECI:  return 15'b0_0_0_00_01_00_1_0_0_0_0;
            P_ALUWB:  return 15'b0_0_0_00_00_00_0_1_0_0_0;
            P_BRANCH: return 15'b0_0_0_00_01_10_0_0_0_1_0;
            default:  return 15'b0_0_0_00_00_00_0_0_0_0_1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // stall_req < 0 picks random memory stalls; abort_at >= 0 drops reset in that phase
    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct,
                             input int stall_req, input int abort_at);
        phase_t ph[$];
        ph = '{P_FETCH, P_DECODE};
        case (op)
            2'b00: begin ph.push_back(funct[5] ? P_EXECI : P_EXECR); ph.push_back(P_ALUWB); end
            2'b01: begin
                ph.push_back(P_MEMADR);
                if (funct[0]) begin ph.push_back(P_MEMRD); ph.push_back(P_MEMWB); end
                else ph.push_back(P_MEMWR);
            end
            2'b10: ph.push_back(P_BRANCH);
            default: ph.push_back(P_UNDEF);
        endcase
        foreach (ph[i]) begin
            int stalls = 0;
`ifdef MEM_WAIT_EN
            if (ph[i] == P_FETCH || ph[i] == P_MEMRD || ph[i] == P_MEMWR)
                stalls = (stall_req >= 0) ? stall_req : int'($urandom_range(0, 3));
`endif
            for (int c = 0; c <= stalls; c++) begin
                @(negedge Clk);
                if (ph[i] == P_DECODE || ph[i] == P_MEMADR) begin
                    bus_if.Op = op;
                    bus_if.Funct = funct;
                end else begin
                    bus_if.Op = 2'($urandom);
                    bus_if.Funct = 6'($urandom);
                end
`ifdef MEM_WAIT_EN
                bus_if.MemReady = (c == stalls);
`endif
                #1;
                chk({"outputs ", ph[i].name()}, 32'(obs), 32'(exp_vec(ph[i])));
                chk({"count ", ph[i].name()}, 32'(bus_if.InstrCount), 32'(model_cnt));
            end
            if (i == abort_at) begin
                #2 Rst = 1'b0;
                #1;
                chk("midreset RegW", 32'(bus_if.RegW), 32'd0);
                chk("midreset outputs", 32'(obs), 32'd0);
                chk("midreset count", 32'(bus_if.InstrCount), 32'd0);
                model_cnt = 0;
                repeat (2) @(negedge Clk);
                chk("reset hold outputs", 32'(obs), 32'd0);
                @(posedge Clk);
                #1 Rst = 1'b1;
                return;
            end
            if (ph[i] == P_FETCH) model_cnt = (model_cnt + 1) % (1 << W);
        end
    endtask

    initial begin
        Rst = 1'b1;
        bus_if.Op = 2'b00;
        bus_if.Funct = 6'b000000;
`ifdef MEM_WAIT_EN
        bus_if.MemReady = 1'b1;
`endif
        #2 Rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("reset outputs", 32'(obs), 32'd0);
            chk("reset count", 32'(bus_if.InstrCount), 32'd0);
        end
        @(posedge Clk);
        #1 Rst = 1'b1;

        run_instr(2'b00, 6'b000000, 0, -1);
        run_instr(2'b01, 6'b011001, -1, -1);
        run_instr(2'b01, 6'b011000, -1, -1);
        run_instr(2'b10, 6'($urandom), -1, -1);
        run_instr(2'b11, 6'($urandom), -1, -1);
        run_instr(2'b00, 6'b100000, -1, -1);
`ifdef MEM_WAIT_EN
        run_instr(2'b01, 6'b011000, 3, -1);
        run_instr(2'b01, 6'b011000, 2, -1);
`endif
        run_instr(2'b01, 6'b011001, 0, 4);

        for (int n = 0; n < 16; n++)
            run_instr(2'($urandom), 6'($urandom), -1, -1);
        @(posedge Clk);
        #1 chk("wrap to zero", 32'(bus_if.InstrCount), 32'd0);

        for (int n = 0; n < 30; n++)
            run_instr(2'($urandom), 6'($urandom), -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
